// File: rtl/mac_array.sv
// mac_array: multi-channel signed multiply-accumulate engine driven by a
// byte protocol (address byte, command byte, operand bytes) from a UART
// receiver, returning accumulator or activation bytes to a UART transmitter.
// Optional build macro MAC_ARRAY_SAT_EN: when defined, MAC results saturate
// at the accumulator limits instead of wrapping.

module mac_array #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 2,
    parameter int BASE_ADDR = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int OB = WIDTH / 8;
    localparam int AB = 2 * WIDTH / 8;
    localparam int AW = 2 * WIDTH;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = $clog2(AB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LOAD,
        S_EXEC,
        S_SEND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic            loadB_q, loadB_d;
    logic            doMac_q, doMac_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   last_q, last_d;
    logic [AW-1:0]   snap_q, snap_d;
    logic            overrun_q, overrun_d;

    logic signed [WIDTH-1:0] opA_q  [CHANNELS];
    logic signed [WIDTH-1:0] opB_q  [CHANNELS];
    logic signed [AW-1:0]    acc_q  [CHANNELS];

    logic signed [WIDTH-1:0] curA, curB;
    logic signed [AW-1:0]    curAcc;
    logic signed [AW-1:0]    prod;
    logic [AW:0]             sum;
    logic signed [AW-1:0]    accNew;

    logic        loadWr, accClr, accWr;
    logic [31:0] rxOff;
    logic        addrHit;

    // Offset of the received byte from the base address; values below the
    // base wrap to huge numbers so one unsigned compare covers both bounds.
    assign rxOff   = {24'd0, rx_data} - 32'(BASE_ADDR);
    assign addrHit = rxOff < 32'(CHANNELS);

    assign tx_valid = (state_q == S_SEND);
    assign tx_data  = snap_q[7:0];
    assign busy     = (state_q != S_IDLE);
    assign overrun  = overrun_q;

    // Pick out the operands and accumulator of the channel latched in CMD.
    always_comb begin
        curA   = '0;
        curB   = '0;
        curAcc = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (chan_q == CW'(n)) begin
                curA   = opA_q[n];
                curB   = opB_q[n];
                curAcc = acc_q[n];
            end
        end
    end

    // Full-precision product and one-bit-wider sum so overflow is visible.
    assign prod = $signed({{WIDTH{curA[WIDTH-1]}}, curA})
                * $signed({{WIDTH{curB[WIDTH-1]}}, curB});
    assign sum  = {curAcc[AW-1], curAcc} + {prod[AW-1], prod};

    // New accumulator value for EXEC: plain product for MUL, wrapped or
    // saturated running sum for MAC.
    always_comb begin
        accNew = prod;
        if (doMac_q) begin
`ifdef MAC_ARRAY_SAT_EN
            if (sum[AW] != sum[AW-1]) begin
                accNew = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                accNew = sum[AW-1:0];
            end
`else
            accNew = sum[AW-1:0];
`endif
        end
    end

    // Protocol FSM: decodes address, command and operand bytes, sequences
    // the transmit bytes, and flags bytes that arrive while it cannot listen.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        loadB_d   = loadB_q;
        doMac_d   = doMac_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        loadWr    = 1'b0;
        accClr    = 1'b0;
        accWr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && addrHit) begin
                    chan_d  = rxOff[CW-1:0];
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    case (rx_data)
                        8'd0: begin
                            loadB_d = 1'b0;
                            state_d = S_LOAD;
                        end
                        8'd1: begin
                            loadB_d = 1'b1;
                            state_d = S_LOAD;
                        end
                        8'd2: begin
                            snap_d  = curAcc;
                            last_d  = NW'(AB - 1);
                            state_d = S_SEND;
                        end
                        8'd3: begin
                            accClr  = 1'b1;
                            state_d = S_IDLE;
                        end
                        8'd4: begin
                            snap_d  = {{(AW-1){1'b0}}, (!curAcc[AW-1] && (curAcc != '0))};
                            last_d  = '0;
                            state_d = S_SEND;
                        end
                        8'd5: begin
                            doMac_d = 1'b0;
                            state_d = S_EXEC;
                        end
                        8'd6: begin
                            doMac_d = 1'b1;
                            state_d = S_EXEC;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    loadWr = 1'b1;
                    cnt_d  = cnt_q + NW'(1);
                    if (cnt_q == NW'(OB - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_EXEC: begin
                accWr   = 1'b1;
                state_d = S_IDLE;
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
            end
            S_SEND: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    snap_d = snap_q >> 8;
                    cnt_d  = cnt_q + NW'(1);
                    if (cnt_q == last_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and transmit-snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chan_q    <= '0;
            loadB_q   <= 1'b0;
            doMac_q   <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            loadB_q   <= loadB_d;
            doMac_q   <= doMac_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

    // Per-channel operand and accumulator storage; only the addressed
    // channel is ever written, and each load byte lands in its own lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                opA_q[n] <= '0;
                opB_q[n] <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (chan_q == CW'(n)) begin
                    for (int k = 0; k < OB; k++) begin
                        if (loadWr && (cnt_q == NW'(k))) begin
                            if (loadB_q) begin
                                opB_q[n][8*k +: 8] <= rx_data;
                            end else begin
                                opA_q[n][8*k +: 8] <= rx_data;
                            end
                        end
                    end
                    if (accClr) begin
                        acc_q[n] <= '0;
                    end else if (accWr) begin
                        acc_q[n] <= accNew;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed bench for mac_array with a transaction-level
// model of every channel's operands and accumulator and a per-cycle
// compare process on the transmit stream and overrun flag.
`timescale 1ns/1ps

module tb_mac_array;

    localparam int WIDTH     = 32;
    localparam int CHANNELS  = 2;
    localparam int BASE_ADDR = 100;
    localparam int AB        = 8;

`ifdef MAC_ARRAY_SAT_EN
    localparam logic [63:0] PIN_OVF = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] PIN_OVF = 64'h8000_0000_0000_0000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    int         mA   [CHANNELS];
    int         mB   [CHANNELS];
    longint     mAcc [CHANNELS];
    logic [7:0] expQ [$];
    logic       expOverrun;

    always #5 clk = ~clk;

    mac_array #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Accumulate with the overflow rule of the selected build.
    function automatic longint modelMac(input longint acc, input longint p);
        longint s;
        s = acc + p;
`ifdef MAC_ARRAY_SAT_EN
        if (acc >= 0 && p >= 0 && s < 0) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (acc < 0 && p < 0 && s >= 0) return 64'h8000_0000_0000_0000;
`endif
        return s;
    endfunction

    // Every cycle out of reset: overrun must match the model, and any byte
    // on offer must be the next one the model expects.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("overrun", overrun, expOverrun);
            if (tx_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedTx", tx_valid, 0);
                end else begin
                    checkOutput("txByte", tx_data, expQ[0]);
                    if (tx_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic modelReset();
        for (int n = 0; n < CHANNELS; n++) begin
            mA[n]   = 0;
            mB[n]   = 0;
            mAcc[n] = 0;
        end
        expQ.delete();
        expOverrun = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        modelReset();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic loadOperand(input int ch, input logic isB, input logic [31:0] val);
        applyStimulus(8'(BASE_ADDR + ch));
        applyStimulus({7'd0, isB});
        for (int k = 0; k < 4; k++) applyStimulus(val[8*k +: 8]);
        checkOutput("loadDoneBusy", busy, 0);
        if (isB) mB[ch] = int'(val);
        else     mA[ch] = int'(val);
    endtask

    task automatic execOp(input int ch, input logic isMac);
        longint p;
        applyStimulus(8'(BASE_ADDR + ch));
        applyStimulus(isMac ? 8'd6 : 8'd5);
        checkOutput("execBusy", busy, 1);
        tick(1);
        checkOutput("execDoneBusy", busy, 0);
        p = longint'(mA[ch]) * longint'(mB[ch]);
        mAcc[ch] = isMac ? modelMac(mAcc[ch], p) : p;
    endtask

    task automatic clearAcc(input int ch);
        applyStimulus(8'(BASE_ADDR + ch));
        applyStimulus(8'd3);
        checkOutput("clearBusy", busy, 0);
        mAcc[ch] = 0;
    endtask

    task automatic pushAcc(input int ch);
        logic [63:0] v;
        v = mAcc[ch];
        for (int k = 0; k < AB; k++) expQ.push_back(v[8*k +: 8]);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("drainTimeout", expQ.size(), 0);
        checkOutput("sendEndValid", tx_valid, 0);
        checkOutput("sendEndBusy", busy, 0);
    endtask

    task automatic readAcc(input int ch);
        pushAcc(ch);
        applyStimulus(8'(BASE_ADDR + ch));
        applyStimulus(8'd2);
        checkOutput("txValidRise", tx_valid, 1);
        waitDrain();
    endtask

    task automatic readAct(input int ch);
        expQ.push_back((mAcc[ch] > 0) ? 8'h01 : 8'h00);
        applyStimulus(8'(BASE_ADDR + ch));
        applyStimulus(8'd4);
        checkOutput("actValidRise", tx_valid, 1);
        waitDrain();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        modelReset();
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset values.
        checkOutput("rstTxValid", tx_valid, 0);
        checkOutput("rstTxData", tx_data, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstOverrun", overrun, 0);

        // Basic MAC on channel 100: 1*1, then +1*1 -> 2.
        loadOperand(0, 1'b0, 32'h0000_0001);
        loadOperand(0, 1'b1, 32'h0000_0001);
        execOp(0, 1'b0);
        execOp(0, 1'b1);
        checkOutput("pinBasic", mAcc[0], 2);
        readAcc(0);

        // Channel isolation: 101 untouched, 102 is not an address.
        readAcc(1);
        applyStimulus(8'd102);
        checkOutput("ignoreAddrBusy", busy, 0);
        applyStimulus(8'd2);
        checkOutput("ignoreCmdBusy", busy, 0);
        tick(3);
        checkOutput("ignoreTxValid", tx_valid, 0);

        // Unknown command returns to IDLE without effect.
        applyStimulus(8'd100);
        applyStimulus(8'd9);
        checkOutput("badCmdBusy", busy, 0);

        // Signed arithmetic: -3 * 5 = -15.
        loadOperand(0, 1'b0, 32'hFFFF_FFFD);
        loadOperand(0, 1'b1, 32'h0000_0005);
        execOp(0, 1'b0);
        checkOutput("pinSigned", mAcc[0], -15);
        readAct(0);
        readAcc(0);
        clearAcc(0);
        readAct(0);

        // Positive activation on the other channel: 7 * 6 = 42.
        loadOperand(1, 1'b0, 32'd7);
        loadOperand(1, 1'b1, 32'd6);
        execOp(1, 1'b0);
        checkOutput("pinPositive", mAcc[1], 42);
        readAct(1);

        // Overflow: 2^62 + 2^62 exceeds the signed accumulator range.
        loadOperand(0, 1'b0, 32'h8000_0000);
        loadOperand(0, 1'b1, 32'h8000_0000);
        execOp(0, 1'b1);
        execOp(0, 1'b1);
        checkOutput("pinOverflow", mAcc[0], PIN_OVF);
        readAcc(0);

        // Reset mid-load: the partial A must not survive.
        applyStimulus(8'd100);
        applyStimulus(8'd0);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        pulseReset();
        checkOutput("midRstBusy", busy, 0);
        loadOperand(0, 1'b1, 32'd9);
        execOp(0, 1'b0);
        readAcc(0);
        loadOperand(0, 1'b0, 32'd3);
        execOp(0, 1'b0);
        checkOutput("pinAfterRst", mAcc[0], 27);
        readAcc(1);

        // Backpressure with an injected byte during SEND.
        tx_ready = 1'b0;
        pushAcc(0);
        applyStimulus(8'd100);
        applyStimulus(8'd2);
        checkOutput("bpValidRise", tx_valid, 1);
        applyStimulus(8'h55);
        expOverrun = 1'b1;
        checkOutput("bpOverrun", overrun, 1);
        tick(48);
        checkOutput("bpStallByte", tx_data, 8'h1B);
        checkOutput("bpStallValid", tx_valid, 1);
        tx_ready = 1'b1;
        waitDrain();
        tick(3);
        checkOutput("stickyOverrun", overrun, 1);
        checkOutput("queueEmpty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
